// File: rtl/quadrature_decoder_pkg.sv
// Shared definitions for the quadrature decoder:
// A/B state encoding and the single-step decode.
package quadrature_decoder_pkg;

  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_01 = 2'b01;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ILL  = 2'd3
  } step_e;

  function automatic logic [1:0] fwd_next(
    input logic [1:0] ab
  );
    logic [1:0] nxt;
    case (ab)
      AB_00:   nxt = AB_01;
      AB_01:   nxt = AB_11;
      AB_11:   nxt = AB_10;
      default: nxt = AB_00;
    endcase
    return nxt;
  endfunction

  // Gray-code walk: one bit flipping is a step, two bits is illegal.
  function automatic step_e step_decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    step_e res;
    if (prev == cur)
      res = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      res = STEP_ILL;
    else if (cur == fwd_next(prev))
      res = STEP_FWD;
    else
      res = STEP_REV;
    return res;
  endfunction

endpackage

// File: rtl/window_timer.sv
// Free-running velocity window counter with
// an end-of-window strobe and registered valid pulse.
module window_timer #(
  parameter int unsigned WINDOW = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic last_o,
  output logic valid_o
);

  localparam int unsigned CW =
    (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q;

  assign last_o  = (cnt_q == CW'(WINDOW - 1));
  assign valid_o = valid_q;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (last_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      valid_q <= last_o;
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: synchronized A/B decode,
// wrapping position counter and windowed velocity stream.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int unsigned POS_WIDTH  = 16,
  parameter int unsigned VEL_WIDTH  = 12,
  parameter int unsigned VEL_WINDOW = 20000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        a,
  input  logic                        b,
  input  logic                        count_clear,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        direction,
  output logic                        step,
  output logic                        illegal,
  output logic signed [VEL_WIDTH-1:0] ast_source_data,
  output logic                        ast_source_valid,
  output logic [1:0]                  ast_source_error
);

  logic [1:0] sync1_q, sync2_q, prev_q, fill_q;
  logic       primed_q;
  step_e      dec;
  logic       fwd, rev, ill_ev, step_ok;

  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic dir_q, dir_d, step_q, step_d, ill_q, ill_d;

  logic [VEL_WIDTH:0]   sum_ext;
  logic [VEL_WIDTH-1:0] sum_q, sum_sat, data_q;
  logic                 ovf, win_sat_q, win_ill_q;
  logic                 sat_any, ill_any;
  logic [1:0]           err_q;
  logic                 win_last;

  // fill_q marks when sync2_q holds a real sample,
  // so the primed load never captures reset junk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      fill_q   <= '0;
      primed_q <= 1'b0;
    end else begin
      sync1_q  <= {a, b};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      fill_q   <= {fill_q[0], 1'b1};
      primed_q <= primed_q | fill_q[1];
    end
  end

  assign dec = primed_q ? step_decode(prev_q, sync2_q)
                        : STEP_NONE;
  assign fwd     = (dec == STEP_FWD);
  assign rev     = (dec == STEP_REV);
  assign ill_ev  = (dec == STEP_ILL);
  assign step_ok = (fwd | rev) & ~count_clear;

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    ill_d  = ill_q;
    if (count_clear) begin
      pos_d = '0;
      ill_d = 1'b0;
    end else begin
      unique case (1'b1)
        fwd: begin
          pos_d  = pos_q + POS_WIDTH'(1);
          dir_d  = 1'b1;
          step_d = 1'b1;
        end
        rev: begin
          pos_d  = pos_q - POS_WIDTH'(1);
          dir_d  = 1'b0;
          step_d = 1'b1;
        end
        ill_ev: ill_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      ill_q  <= ill_d;
    end
  end

  // One extra bit catches a +/-1 overflow; clamp to the rail.
  always_comb begin
    sum_ext = {sum_q[VEL_WIDTH-1], sum_q};
    if (step_ok) begin
      if (fwd) sum_ext = sum_ext + (VEL_WIDTH+1)'(1);
      else     sum_ext = sum_ext - (VEL_WIDTH+1)'(1);
    end
    ovf     = sum_ext[VEL_WIDTH] ^ sum_ext[VEL_WIDTH-1];
    sum_sat = sum_ext[VEL_WIDTH-1:0];
    if (ovf)
      sum_sat = {sum_ext[VEL_WIDTH],
                 {(VEL_WIDTH-1){~sum_ext[VEL_WIDTH]}}};
    sat_any = win_sat_q | ovf;
    ill_any = win_ill_q | ill_ev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q     <= '0;
      win_sat_q <= 1'b0;
      win_ill_q <= 1'b0;
      data_q    <= '0;
      err_q     <= '0;
    end else if (win_last) begin
      sum_q     <= '0;
      win_sat_q <= 1'b0;
      win_ill_q <= 1'b0;
      data_q    <= sum_sat;
      err_q     <= {sat_any, ill_any};
    end else begin
      sum_q     <= sum_sat;
      win_sat_q <= sat_any;
      win_ill_q <= ill_any;
    end
  end

  window_timer #(
    .WINDOW (VEL_WINDOW)
  ) u_window_timer (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .last_o  (win_last),
    .valid_o (ast_source_valid)
  );

  assign position         = pos_q;
  assign direction        = dir_q;
  assign step             = step_q;
  assign illegal          = ill_q;
  assign ast_source_data  = data_q;
  assign ast_source_error = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: two instances (12-bit and
// 4-bit velocity) driven together against a step-level model.
module tb_quadrature_decoder;

  localparam int W = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic count_clear = 1'b0;

  logic [15:0] p0, p1;
  logic        d0, d1, s0, s1, i0, i1, v0, v1;
  logic [11:0] vd0;
  logic [3:0]  vd1;
  logic [1:0]  e0, e1;

  quadrature_decoder #(
    .POS_WIDTH(16), .VEL_WIDTH(12), .VEL_WINDOW(W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b),
    .count_clear(count_clear), .position(p0),
    .direction(d0), .step(s0), .illegal(i0),
    .ast_source_data(vd0), .ast_source_valid(v0),
    .ast_source_error(e0)
  );

  quadrature_decoder #(
    .POS_WIDTH(16), .VEL_WIDTH(4), .VEL_WINDOW(W)
  ) dut_s (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b),
    .count_clear(count_clear), .position(p1),
    .direction(d1), .step(s1), .illegal(i1),
    .ast_source_data(vd1), .ast_source_valid(v1),
    .ast_source_error(e1)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int wbase = 0;

  // Gray-walk position of each {a,b} value, and its inverse.
  int         gidx[4] = '{0, 1, 3, 2};
  logic [1:0] gab[4]  = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [1:0] ab_m = 2'b00;
  int         ev[int];

  logic [15:0] m_pos;
  bit   m_dir, m_ill, m_step, m_v;
  int   ws12, ws4, ed12, ed4;
  bit   wsat12, wsat4, will;
  bit   [1:0] ee12, ee4;

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  function automatic int satw(input int s, input int w,
                              output bit hit);
    int hi, lo;
    hi  = (1 << (w - 1)) - 1;
    lo  = -(1 << (w - 1));
    hit = 1'b0;
    if (s > hi) begin hit = 1'b1; return hi; end
    if (s < lo) begin hit = 1'b1; return lo; end
    return s;
  endfunction

  task automatic model_zero();
    m_pos = '0; m_dir = 0; m_step = 0; m_ill = 0; m_v = 0;
    ws12 = 0; ws4 = 0; ed12 = 0; ed4 = 0;
    wsat12 = 0; wsat4 = 0; will = 0; ee12 = 0; ee4 = 0;
  endtask

  task automatic check_all();
    chk("position", p0, m_pos);
    chk("direction", d0, m_dir);
    chk("step", s0, m_step);
    chk("illegal", i0, m_ill);
    chk("valid", v0, m_v);
    chk("vel_data", $signed(vd0), ed12);
    chk("vel_error", e0, ee12);
    chk("valid_s", v1, m_v);
    chk("vel_data_s", $signed(vd1), ed4);
    chk("vel_error_s", e1, ee4);
  endtask

  task automatic tick();
    bit clr, h;
    int k;
    @(posedge clk);
    edge_n++;
    clr = count_clear;
    if (!reset_n) begin
      model_zero();
    end else begin
      k = 0;
      if (ev.exists(edge_n)) begin
        k = ev[edge_n];
        ev.delete(edge_n);
      end
      m_step = 0;
      m_v = 0;
      if (k == 2) will = 1;
      if (clr) begin
        m_pos = '0;
        m_ill = 0;
      end else if (k == 2) begin
        m_ill = 1;
      end else if (k != 0) begin
        m_pos  = 16'(int'(m_pos) + k);
        m_dir  = (k > 0);
        m_step = 1;
        ws12 = satw(ws12 + k, 12, h); wsat12 |= h;
        ws4  = satw(ws4 + k, 4, h);   wsat4  |= h;
      end
      if (((edge_n - wbase) % W) == 0) begin
        m_v = 1;
        ed12 = ws12; ee12 = {wsat12, will};
        ed4  = ws4;  ee4  = {wsat4, will};
        ws12 = 0; ws4 = 0;
        wsat12 = 0; wsat4 = 0; will = 0;
      end
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // kind: 1 forward, -1 reverse, 2 illegal (both bits flip).
  task automatic move(input int kind);
    int g;
    g = (gidx[ab_m] + kind + 4) % 4;
    ab_m = gab[g];
    {a, b} = ab_m;
    ev[edge_n + 3] = kind;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    {a, b} = 2'b00;
    ab_m = 2'b00;
    count_clear = 1'b0;
    ev.delete();
    model_zero();
    #2;
    check_all();
    ticks(n);
    reset_n = 1'b1;
    wbase = edge_n;
    ticks(5);
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (!v0 && t < 2 * W) begin
      tick();
      t++;
    end
    chk(tag, v0, 1);
  endtask

  initial begin
    int st, r;
    model_zero();
    ticks(3);
    reset_n = 1'b1;
    wbase = edge_n;
    ticks(5);

    // Forward rotation with a fixed per-edge latency.
    for (int i = 0; i < 8; i++) begin
      move(1);
      st = 0;
      for (int c = 1; c <= 3; c++) begin
        tick();
        if (s0) st = c;
      end
      chk("fwd_latency", st, 3);
    end
    ticks(2);
    chk("fwd_pos8", p0, 16'd8);
    chk("fwd_dir", d0, 1);

    // Illegal jump, then clear.
    move(2);
    ticks(4);
    chk("ill_flag", i0, 1);
    chk("ill_pos", p0, 16'd8);
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    tick();
    chk("clr_ill", i0, 0);
    chk("clr_pos", p0, 0);

    // Reverse step through zero wraps.
    move(-1);
    ticks(4);
    chk("rev_wrap", p0, 16'hFFFF);
    chk("rev_dir", d0, 0);

    // Clear lands on the same edge as a decoded step.
    move(1);
    ticks(2);
    count_clear = 1'b1;
    tick();
    count_clear = 1'b0;
    chk("clr_vs_step_pos", p0, 0);
    chk("clr_vs_step_nostep", s0, 0);
    ticks(2);

    // Align to a window start, then 30 forward steps.
    while (((edge_n - wbase) % W) != 0) tick();
    for (int i = 0; i < 30; i++) begin
      move(1);
      ticks(2);
    end
    wait_valid("win30_valid");
    chk("win30_data", $signed(vd0), 30);
    chk("win30_err", e0, 2'b00);
    chk("win30_sat_data", $signed(vd1), 7);
    chk("win30_sat_err", e1, 2'b10);
    tick();
    chk("valid_one_cycle", v0, 0);

    // Randomized motion, illegal jumps and clears.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0)      move(2);
      else if (r < 10) move(1);
      else if (r < 17) move(-1);
      count_clear = ($urandom_range(0, 24) == 0);
      ticks($urandom_range(1, 3));
      count_clear = 1'b0;
    end
    ticks(5);

    // Reset in the middle of a window.
    while (((edge_n - wbase) % W) != 40) tick();
    for (int i = 0; i < 10; i++) begin
      move(1);
      ticks(2);
    end
    do_reset(3);
    chk("rst_pos", p0, 0);
    chk("rst_data", $signed(vd0), 0);
    st = 0;
    for (int i = 0; i < W - 10; i++) begin
      tick();
      if (v0) st++;
    end
    chk("rst_no_early_valid", st, 0);
    wait_valid("rst_window_valid");
    chk("rst_window_data", $signed(vd0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 SHALL have parameter POS_WIDTH, default 16: width of the signed position counter.
REQ-002 SHALL have parameter VEL_WIDTH, default 12: width of the signed velocity sample.
REQ-003 SHALL have parameter VEL_WINDOW, default 20000: clk cycles per velocity window (1 ms at 20 MHz).
REQ-004 SHALL have port: clk  input  1  sole clock for all logic (20 MHz system clock).
REQ-005 SHALL have port: reset_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port: a  input  1  encoder channel A, asynchronous to clk.
REQ-007 SHALL have port: b  input  1  encoder channel B, asynchronous to clk.
REQ-008 SHALL have port: count_clear  input  1  synchronous clear of position and error.
REQ-009 SHALL have port: position  output  POS_WIDTH  signed accumulated step count.
REQ-010 SHALL have port: direction  output  1  direction of the last legal step, 1 = forward.
REQ-011 SHALL have port: step  output  1  one-cycle pulse per legal step.
REQ-012 SHALL have port: illegal  output  1  sticky flag for a two-bit transition.
REQ-013 SHALL have port: ast_source_data  output  VEL_WIDTH  signed steps counted in the last window.
REQ-014 SHALL have port: ast_source_valid  output  1  one-cycle qualifier for ast_source_data.
REQ-015 SHALL have port: ast_source_error  output  2  bit0 = illegal transition in window; bit1 = saturation.

Function
REQ-016 SHALL pass a and b each through a two-flop synchronizer before any use.
REQ-017 SHALL register the previous synchronized {a,b} pair and decode each current/previous pair as follows:
- forward (+1): 00->01->11->10->00.
- reverse (-1): the opposite sequence.
- no change: no action.
- both bits changing: illegal.
REQ-018 SHALL update position, direction and step in the cycle after the synchronized change, giving 3 clk cycles from an a/b edge to the position update.
REQ-019 SHALL wrap position in two's complement: max positive +1 gives max negative, and the reverse.
REQ-020 SHALL, on an illegal transition, leave position unchanged, pulse no step, and set illegal until count_clear or reset.
REQ-021 SHALL give count_clear priority over a simultaneous step: position goes to 0, illegal to 0, and that step is dropped.
REQ-022 SHALL NOT decode a step on the first synchronized sample after reset; a primed flag loads the previous pair without decoding.
REQ-023 SHALL run a free window counter 0..VEL_WINDOW-1 that is not affected by count_clear.
REQ-024 SHALL accumulate a signed window step sum and saturate it at the VEL_WIDTH limits.
REQ-025 SHALL, at window count VEL_WINDOW-1:
- present the window sum, including any step in that same cycle, on ast_source_data with ast_source_valid high for exactly 1 cycle;
- restart the sum at 0.
REQ-026 SHALL set ast_source_error bit0 if any illegal transition occurred in the window, and bit1 if the sum saturated; both bits reset per window.
REQ-027 SHALL hold ast_source_data and ast_source_error between valid pulses; there is no backpressure.

Reset
REQ-028 SHALL, while reset_n is low, drive position 0, direction 0, step 0, illegal 0, ast_source_data 0, ast_source_valid 0 and ast_source_error 0.
REQ-029 SHALL, while reset_n is low, clear the synchronizers, primed flag, window counter and window sum.
REQ-030 SHALL discard a partial window when reset asserts mid-window, with no valid pulse; counting restarts from 0 after release.

Structure
REQ-031 SHALL place the 2-bit state encoding constants and the step decode (+1/-1/0/illegal) in the shared lab package.
REQ-032 SHALL instantiate the free-running window counter and valid-pulse logic as one sub-module, window_timer.

Verification
REQ-033 SHALL cover forward rotation: 8 forward steps from 00 -> position 8, direction 1, 8 step pulses, each 3 cycles after its edge.
REQ-034 SHALL cover reverse wrap: from position 0, 1 reverse step -> position 16'hFFFF, direction 0.
REQ-035 SHALL cover an illegal transition: 00->11 -> illegal 1, position unchanged, no step; count_clear -> illegal 0, position 0.
REQ-036 SHALL cover clear versus step: count_clear in the same cycle as a decoded step -> position 0 on the next cycle.
REQ-037 SHALL cover a velocity window: VEL_WINDOW=100, 30 forward steps within one window -> ast_source_data 30, valid for 1 cycle at cycle 99, error 00.
REQ-038 SHALL cover saturation and reset: VEL_WIDTH=4, 10 forward steps -> data 7, error bit1 set; reset_n low mid-window -> all outputs 0 and no valid pulse.
